// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Bundles the fetch stage's memory bus, redirect input and decode-side
//   valid/ready handshake.
//   master : fetch stage (drives imem_addr and the out_* payload)
//   slave  : environment (memory, branch unit, decode)
// Signals:
//   imem_addr      fetch -> mem     byte address, ADDR_W bits
//   imem_rdata     mem -> fetch     32-bit word, one edge after address
//   redirect_valid branch -> fetch  taken branch/jump this cycle
//   redirect_pc    branch -> fetch  redirect target (bits [1:0] ignored)
//   out_valid      fetch -> decode  head entry valid
//   out_ready      decode -> fetch  head accepted this cycle
//   out_instr      fetch -> decode  head instruction word
//   out_pc         fetch -> decode  byte address of out_instr
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage for a synchronous-read instruction memory. Issues byte
//   addresses, tracks the one-cycle read latency, squashes stale reads on
//   redirect and buffers returned words in a small FIFO so decode
//   back-pressure never drops an instruction.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  instruction_fetch_if.master (memory bus, redirect, decode handshake)
// Parameters:
//   ADDR_W    byte-address width of instruction memory
//   RESET_PC  first fetch address after reset (word aligned)
// Build option:
//   IFETCH_SKID_EN  defined -> 2-entry FIFO, 1 instr/cycle
//                   undefined -> 1-entry FIFO, 1 instr per 2 cycles
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  instruction_fetch_if.master  bus
);

`ifdef IFETCH_SKID_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif
  // Storage is always two slots; with DEPTH 1 only slot 0 is ever used.
  localparam int unsigned SLOTS = 2;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] pc_mem_q [SLOTS];
  logic [ADDR_W-1:0] pc_mem_d [SLOTS];
  logic [31:0]       instr_mem_q [SLOTS];
  logic [31:0]       instr_mem_d [SLOTS];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              out_valid_w;
  logic              deq, enq, issue;
  logic [2:0]        occ;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  function automatic logic ptr_inc(input logic p);
    return (DEPTH > 1) ? ~p : 1'b0;
  endfunction

  assign out_valid_w   = (cnt_q != 2'd0);
  assign bus.out_valid = out_valid_w;
  assign bus.out_instr = out_valid_w ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc    = out_valid_w ? pc_mem_q[rd_ptr_q]    : '0;
  assign bus.imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;

    deq   = out_valid_w & bus.out_ready;
    enq   = inflight_q & ~bus.redirect_valid;
    // Occupancy after this edge counts the read already in flight, so a
    // newly issued read always has a slot when it returns.
    occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, deq};
    issue = ~bus.redirect_valid & (occ < 3'(DEPTH));

    if (bus.redirect_valid) begin
      cnt_d      = '0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      inflight_d = 1'b0;
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      if (enq) begin
        pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        instr_mem_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      cnt_d = cnt_q + {1'b0, enq} - {1'b0, deq};
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      cnt_q         <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Directed bench for instruction_fetch with a synchronous-read memory
//   model. Expectations follow the IFETCH_SKID_EN setting of the build.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  instruction_fetch_if #(.ADDR_W(10)) bus ();

  instruction_fetch #(
    .ADDR_W  (10),
    .RESET_PC(10'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [9:0] a);
    if (a == 10'h000)      return 32'h0000_0013;
    else if (a == 10'h004) return 32'h0010_0093;
    else                   return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  always @(posedge clk) bus.imem_rdata <= word(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [9:0] pc);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
    chk({tag, "_instr"}, bus.out_instr, word(pc));
  endtask

  // Walks the stream until n instructions are seen, each must carry the next
  // sequential pc; a stalled stream runs out of budget and fails the count.
  task automatic collect(input string tag, input logic [9:0] first, input int n);
    logic [9:0] exp_pc = first;
    int got = 0;
    int budget = 4 * n + 4;
    while (got < n && budget > 0) begin
      if (bus.out_valid) begin
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'(exp_pc));
        chk({tag, "_instr"}, bus.out_instr, word(exp_pc));
        exp_pc += 10'd4;
        got++;
      end
      tick();
      budget--;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) tick();
  endtask

  initial begin
    logic [9:0] exp_pc;

    // Reset values and basic stream
    do_reset();
    chk("rst_addr", 32'(bus.imem_addr), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_pc", 32'(bus.out_pc), 32'h0);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    tick();  // E0
    chk("e0_valid", 32'(bus.out_valid), 32'd0);
    chk("e0_addr", 32'(bus.imem_addr), 32'h4);
    tick();  // E1
    chk_head("e1", 10'h000);
`ifdef IFETCH_SKID_EN
    tick();
    chk_head("e2", 10'h004);
    exp_pc = 10'h008;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_head("stream", exp_pc);
      exp_pc += 10'd4;
    end
`else
    tick();
    chk("e2_gap", 32'(bus.out_valid), 32'd0);
    tick();
    chk_head("e3", 10'h004);
    exp_pc = 10'h008;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_gap", 32'(bus.out_valid), 32'd0);
      chk("stream_gap_pc", 32'(bus.out_pc), 32'h0);
      tick();
      chk_head("stream", exp_pc);
      exp_pc += 10'd4;
    end
`endif

    // Back-pressure: head held, fetch stalls, release delivers in order
    do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk_head("bp_first", 10'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("bp_hold", 10'h000);
`ifdef IFETCH_SKID_EN
      chk("bp_addr", 32'(bus.imem_addr), 32'h8);
`else
      chk("bp_addr", 32'(bus.imem_addr), 32'h4);
`endif
    end
    bus.out_ready = 1'b1;
    collect("bp_rel", 10'h000, 3);

    // Redirect with FIFO full; head offered to decode at the same time
    do_reset();
    rst = 1'b0;
    repeat (4) tick();
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h102;
    tick();  // R
    bus.redirect_valid = 1'b0;
    chk("rd_r_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_r_addr", 32'(bus.imem_addr), 32'h100);
    tick();  // R+1
    chk("rd_r1_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_r1_addr", 32'(bus.imem_addr), 32'h104);
    tick();  // R+2
    chk_head("rd_r2", 10'h100);
    tick();
    collect("rd_after", 10'h104, 3);

    // Address wrap at the top of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h3F8;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wr_r_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("wr_r1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk_head("wr_r2", 10'h3F8);
    tick();
    collect("wrap", 10'h3FC, 2);

    // Asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_instr", bus.out_instr, 32'h0);
    chk("mrst_pc", 32'(bus.out_pc), 32'h0);
    chk("mrst_addr", 32'(bus.imem_addr), 32'h0);
    tick();
    rst = 1'b0;
    tick();  // E0
    chk("mrst_e0_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_e0_addr", 32'(bus.imem_addr), 32'h4);
    tick();  // E1
    chk_head("mrst_e1", 10'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
